// File: rtl/burst_req_if.sv
// Host <-> burst engine bus for burst_req_tx.
// master: host/test side (drives the command and the returned serial stream).
// slave : burst_req_tx.
interface burst_req_if #(
  parameter int LEN_W  = 4,
  parameter int ADDR_W = 16
);
  logic              start;
  logic              mode_sel_in;
  logic [LEN_W-1:0]  burst_len;
  logic [ADDR_W-1:0] start_addr;
  logic              en_out;
  logic              mode_sel_out;
  logic              len_sdo;
  logic              addr_sdo;
  logic              addr_sdi;
  logic              addr_sdi_valid;
  logic              busy;
  logic              done;
  logic              err;
  logic [LEN_W:0]    beat_cnt;
  logic [ADDR_W-1:0] last_addr;

  modport master (
    output start, mode_sel_in, burst_len, start_addr, addr_sdi, addr_sdi_valid,
    input  en_out, mode_sel_out, len_sdo, addr_sdo, busy, done, err, beat_cnt, last_addr
  );

  modport slave (
    input  start, mode_sel_in, burst_len, start_addr, addr_sdi, addr_sdi_valid,
    output en_out, mode_sel_out, len_sdo, addr_sdo, busy, done, err, beat_cnt, last_addr
  );
endinterface

// File: rtl/burst_req_tx.sv
// burst_req_tx: serialises a burst command (mode, length, start address) to the
// burst engine, then deserialises the returned address words and checks them
// against an incrementing sequence.
// Optional: define BURST_TX_TIMEOUT_EN to abort WAIT_BEAT after TIMEOUT_CYC
// idle cycles (err set, done pulses). Without it WAIT_BEAT waits forever.
module burst_req_tx #(
  parameter int LEN_W       = 4,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  burst_req_if.slave bus
);
  localparam int CW = $clog2(ADDR_W);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_BEAT, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;   // outgoing address, shifted right
  logic [LEN_W-1:0]  len_sh_q, len_sh_d;     // outgoing length, zero-fills
  logic [LEN_W:0]    eff_len_q, eff_len_d;
  logic [LEN_W:0]    beat_cnt_q, beat_cnt_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;   // shared by SHIFT and receive
  logic [ADDR_W-1:0] rx_q, rx_d;
  logic [ADDR_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              mode_q, mode_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] rx_word;

`ifdef BURST_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q, to_d;
`endif

  // Word as it will look once the current bit lands (LSB first => shift right)
  assign rx_word = {bus.addr_sdi, rx_q[ADDR_W-1:1]};

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    addr_sh_d  = addr_sh_q;
    len_sh_d   = len_sh_q;
    eff_len_d  = eff_len_q;
    beat_cnt_d = beat_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    exp_d      = exp_q;
    last_d     = last_q;
    mode_d     = mode_q;
    err_d      = err_q;
`ifdef BURST_TX_TIMEOUT_EN
    to_d       = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d     = bus.mode_sel_in;
          addr_sh_d  = bus.start_addr;
          // Single mode sends a zero length field but still expects one word
          len_sh_d   = bus.mode_sel_in ? bus.burst_len : '0;
          eff_len_d  = bus.mode_sel_in ? {1'b0, bus.burst_len} : (LEN_W+1)'(1);
          err_d      = 1'b0;
          beat_cnt_d = '0;
          bit_cnt_d  = '0;
          rx_d       = '0;
          exp_d      = bus.start_addr;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        addr_sh_d = addr_sh_q >> 1;
        len_sh_d  = len_sh_q >> 1;
        if (bit_cnt_q == CW'(ADDR_W-1)) begin
          bit_cnt_d = '0;
          state_d   = (eff_len_q == '0) ? DONE : WAIT_BEAT;
`ifdef BURST_TX_TIMEOUT_EN
          to_d      = '0;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      WAIT_BEAT: begin
        if (bus.addr_sdi_valid) begin
          rx_d = rx_word;
`ifdef BURST_TX_TIMEOUT_EN
          to_d = '0;
`endif
          if (bit_cnt_q == CW'(ADDR_W-1)) begin
            bit_cnt_d  = '0;
            last_d     = rx_word;
            beat_cnt_d = beat_cnt_q + 1'b1;
            exp_d      = exp_q + 1'b1;
            if (rx_word != exp_q) err_d = 1'b1;
            if ((beat_cnt_q + 1'b1) == eff_len_q) state_d = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
`ifdef BURST_TX_TIMEOUT_EN
        else if (to_q == TW'(TIMEOUT_CYC-1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_sh_q  <= '0;
      len_sh_q   <= '0;
      eff_len_q  <= '0;
      beat_cnt_q <= '0;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      exp_q      <= '0;
      last_q     <= '0;
      mode_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_sh_q  <= addr_sh_d;
      len_sh_q   <= len_sh_d;
      eff_len_q  <= eff_len_d;
      beat_cnt_q <= beat_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      exp_q      <= exp_d;
      last_q     <= last_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
    end
  end

`ifdef BURST_TX_TIMEOUT_EN
  // Idle-cycle counter for the WAIT_BEAT abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end
`endif

  assign bus.en_out       = (state_q == SHIFT) || (state_q == WAIT_BEAT);
  assign bus.addr_sdo     = (state_q == SHIFT) && addr_sh_q[0];
  assign bus.len_sdo      = (state_q == SHIFT) && len_sh_q[0];
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.mode_sel_out = mode_q;
  assign bus.err          = err_q;
  assign bus.beat_cnt     = beat_cnt_q;
  assign bus.last_addr    = last_q;
endmodule

// File: tb/tb_burst_req_tx.sv
// Bench for burst_req_tx: transaction-level model of the expected serial frame,
// returned-word bookkeeping and handshake, compared every cycle.
module tb_burst_req_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  burst_req_if #(.LEN_W(4), .ADDR_W(16)) bif ();
  burst_req_tx #(.LEN_W(4), .ADDR_W(16), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .bus(bif)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  // expected outputs for the current cycle
  logic        m_en = 0, m_addr_sdo = 0, m_len_sdo = 0, m_busy = 0, m_done = 0;
  logic        m_err = 0, m_mode = 0;
  logic [4:0]  m_beat = 0;
  logic [15:0] m_last = 0;

  logic [15:0] ret_q[$];
  logic [15:0] cap_addr, cap_len;
  bit          en_all;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (bif.done) done_cnt++;

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("en_out",       bif.en_out,       m_en);
      check("addr_sdo",     bif.addr_sdo,     m_addr_sdo);
      check("len_sdo",      bif.len_sdo,      m_len_sdo);
      check("busy",         bif.busy,         m_busy);
      check("done",         bif.done,         m_done);
      check("err",          bif.err,          m_err);
      check("mode_sel_out", bif.mode_sel_out, m_mode);
      check("beat_cnt",     bif.beat_cnt,     m_beat);
      check("last_addr",    bif.last_addr,    m_last);
    end
  end

  // One transaction. Called in an IDLE cycle just after a posedge.
  // dc = cycles from the accepting edge to the done cycle.
  task automatic run_txn(input bit mode, input logic [3:0] len, input logic [15:0] addr,
                         input bit gap, input bit mid, input bit no_ret, output int dc);
    int t, eff;
    logic [15:0] lsh, ew;
    eff = mode ? int'(len) : 1;
    bif.start = 1; bif.mode_sel_in = mode; bif.burst_len = len; bif.start_addr = addr;
    @(posedge clk); #1; t = 1;
    // changes after acceptance must not matter
    bif.start = 0; bif.mode_sel_in = ~mode;
    bif.burst_len = 4'($urandom); bif.start_addr = 16'($urandom);
    m_err = 0; m_beat = 0; m_mode = mode; m_en = 1; m_busy = 1; m_done = 0;
    en_all = 1;
    for (int k = 0; k < 16; k++) begin
      lsh = 16'(len) >> k;
      m_addr_sdo = addr[k];
      m_len_sdo  = mode & lsh[0];
      @(negedge clk);
      cap_addr[k] = bif.addr_sdo; cap_len[k] = bif.len_sdo; en_all &= bif.en_out;
      @(posedge clk); #1; t++;
    end
    m_addr_sdo = 0; m_len_sdo = 0;
    if (no_ret) begin
      bif.addr_sdi_valid = 0;
      repeat (8) begin @(posedge clk); #1; t++; end
      m_err = 1;
    end else begin
      for (int w = 0; w < eff; w++) begin
        ew = addr + 16'(w);
        for (int b = 0; b < 16; b++) begin
          if (gap) begin
            bif.addr_sdi_valid = 0; bif.addr_sdi = 1'($urandom); bif.start = mid;
            @(posedge clk); #1; t++;
          end
          bif.addr_sdi_valid = 1; bif.addr_sdi = ret_q[w][b]; bif.start = mid;
          @(posedge clk); #1; t++;
          if (b == 15) begin
            m_beat++; m_last = ret_q[w];
            if (ret_q[w] != ew) m_err = 1;
          end
        end
      end
    end
    // DONE cycle: a stray bit and a start here must be ignored
    m_en = 0; m_done = 1; dc = t;
    bif.addr_sdi_valid = 1; bif.addr_sdi = 1; bif.start = mid;
    @(posedge clk); #1;
    m_done = 0; m_busy = 0;
    bif.addr_sdi_valid = 0; bif.addr_sdi = 0; bif.start = 0;
  endtask

  initial begin
    int dc, dn;
    bif.start = 0; bif.mode_sel_in = 0; bif.burst_len = 0; bif.start_addr = 0;
    bif.addr_sdi = 0; bif.addr_sdi_valid = 0;
    repeat (2) @(posedge clk); #1;
    check("rst_busy", bif.busy, 0);
    check("rst_en", bif.en_out, 0);
    check("rst_done", bif.done, 0);
    check("rst_beat", bif.beat_cnt, 0);
    check("rst_last", bif.last_addr, 0);
    rst = 0; chk_en = 1;
    @(posedge clk); #1;

    // frame + good burst
    ret_q = '{16'h00A5, 16'h00A6, 16'h00A7, 16'h00A8};
    dn = done_cnt;
    run_txn(1, 4'd4, 16'h00A5, 0, 0, 0, dc);
    check("frame_addr", cap_addr, 16'h00A5);
    check("frame_len", cap_len, 16'h0004);
    check("frame_en", en_all, 1);
    check("good_dc", dc, 81);
    check("good_beat", bif.beat_cnt, 4);
    check("good_last", bif.last_addr, 16'h00A8);
    check("good_err", bif.err, 0);
    check("good_done_pulses", done_cnt - dn, 1);

    // wrap
    ret_q = '{16'hFFFE, 16'hFFFF, 16'h0000};
    run_txn(1, 4'd3, 16'hFFFE, 0, 0, 0, dc);
    check("wrap_err", bif.err, 0);
    check("wrap_last", bif.last_addr, 16'h0000);

    // mismatch on third word
    ret_q = '{16'hFFFE, 16'hFFFF, 16'h0001};
    dn = done_cnt;
    run_txn(1, 4'd3, 16'hFFFE, 0, 0, 0, dc);
    check("mism_err", bif.err, 1);
    check("mism_beat", bif.beat_cnt, 3);
    check("mism_done_pulses", done_cnt - dn, 1);

    // single mode
    ret_q = '{16'h1234};
    run_txn(0, 4'd7, 16'h1234, 0, 0, 0, dc);
    check("single_len", cap_len, 16'h0000);
    check("single_dc", dc, 33);
    check("single_beat", bif.beat_cnt, 1);
    check("single_err", bif.err, 0);

    // gapped valid, start held during WAIT_BEAT/DONE
    ret_q = '{16'h5A5A, 16'h5A5B};
    run_txn(1, 4'd2, 16'h5A5A, 1, 1, 0, dc);
    check("gap_beat", bif.beat_cnt, 2);
    check("gap_last", bif.last_addr, 16'h5A5B);
    check("gap_busy_after", bif.busy, 0);

    // zero-length burst
    ret_q = {};
    run_txn(1, 4'd0, 16'h0F0F, 0, 0, 0, dc);
    check("zero_dc", dc, 17);
    check("zero_beat", bif.beat_cnt, 0);

    // reset in the middle of SHIFT
    chk_en = 0;
    bif.start = 1; bif.mode_sel_in = 1; bif.burst_len = 4'd5; bif.start_addr = 16'hBEEF;
    @(posedge clk); #1; bif.start = 0;
    repeat (4) @(posedge clk); #1;
    check("mid_busy", bif.busy, 1);
    dn = done_cnt;
    rst = 1; #1;
    check("mid_rst_busy", bif.busy, 0);
    check("mid_rst_en", bif.en_out, 0);
    check("mid_rst_mode", bif.mode_sel_out, 0);
    check("mid_rst_last", bif.last_addr, 0);
    check("mid_rst_sdo", bif.addr_sdo, 0);
    m_en = 0; m_addr_sdo = 0; m_len_sdo = 0; m_busy = 0; m_done = 0;
    m_err = 0; m_mode = 0; m_beat = 0; m_last = 0;
    repeat (3) @(posedge clk); #1;
    rst = 0;
    repeat (20) @(posedge clk); #1;
    check("mid_no_done", done_cnt - dn, 0);
    chk_en = 1;

`ifdef BURST_TX_TIMEOUT_EN
    // no returned bits: abort 8 cycles after WAIT_BEAT entry
    ret_q = {};
    run_txn(1, 4'd2, 16'h1111, 0, 0, 1, dc);
    check("to_dc", dc, 25);
    check("to_err", bif.err, 1);
    check("to_beat", bif.beat_cnt, 0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
